// File: rtl/inst_injector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_injector: RV32I command encoder feeding a DEPTH-entry instruction     |
// | FIFO. Optional macro INJ_IMM_CHECK_EN rejects unrepresentable immediates.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module inst_injector #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_rs1,
    input  logic [4:0]        cmd_rs2,
    input  logic [2:0]        cmd_funct3,
    input  logic              cmd_alt,
    input  logic [31:0]       cmd_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W:0]   count,
    output logic              err
);

    localparam logic [31:0]     c_nop  = 32'h0000_0013;
    localparam logic [ADDR_W:0] c_full = (ADDR_W + 1)'(DEPTH);

    logic [31:0]     r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0] r_count;
    logic            r_err;

    logic [31:0] w_inst;
    logic        w_legal;
    logic        w_imm_ok;
    logic        w_shift;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

    assign w_shift = (cmd_funct3 == 3'b001) || (cmd_funct3 == 3'b101);

    always_comb begin
        w_legal = 1'b1;
        w_inst  = c_nop;
        case (cmd_op)
            4'd0: w_inst = {1'b0, cmd_alt, 5'b0, cmd_rs2, cmd_rs1, cmd_funct3, cmd_rd, 7'b0110011};
            4'd1: begin
                if (w_shift)
                    w_inst = {1'b0, cmd_alt, 5'b0, cmd_imm[4:0], cmd_rs1, cmd_funct3, cmd_rd, 7'b0010011};
                else
                    w_inst = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, 7'b0010011};
            end
            4'd2: w_inst = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, 7'b0000011};
            4'd3: w_inst = {cmd_imm[11:5], cmd_rs2, cmd_rs1, cmd_funct3, cmd_imm[4:0], 7'b0100011};
            4'd4: w_inst = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, cmd_funct3,
                            cmd_imm[4:1], cmd_imm[11], 7'b1100011};
            4'd5: w_inst = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12], cmd_rd, 7'b1101111};
            4'd6: w_inst = {cmd_imm[11:0], cmd_rs1, 3'b000, cmd_rd, 7'b1100111};
            4'd7: w_inst = {cmd_imm[31:12], cmd_rd, 7'b0010111};
            4'd8: w_inst = {cmd_imm[31:12], cmd_rd, 7'b0110111};
            default: w_legal = 1'b0;
        endcase
    end

`ifdef INJ_IMM_CHECK_EN
    logic signed [31:0] w_simm;
    logic               w_i12_ok;

    assign w_simm   = $signed(cmd_imm);
    assign w_i12_ok = (w_simm >= -32'sd2048) && (w_simm <= 32'sd2047);

    always_comb begin
        w_imm_ok = 1'b1;
        case (cmd_op)
            4'd1:             w_imm_ok = w_shift ? (cmd_imm[31:5] == 27'd0) : w_i12_ok;
            4'd2, 4'd3, 4'd6: w_imm_ok = w_i12_ok;
            4'd4: w_imm_ok = (w_simm >= -32'sd4096) && (w_simm <= 32'sd4094) && !cmd_imm[0];
            4'd5: w_imm_ok = (w_simm >= -32'sd1048576) && (w_simm <= 32'sd1048574) && !cmd_imm[0];
            4'd7, 4'd8:       w_imm_ok = (cmd_imm[11:0] == 12'd0);
            default:          w_imm_ok = 1'b1;
        endcase
    end
`else
    assign w_imm_ok = 1'b1;
`endif

    assign cmd_ready = (r_count != c_full);
    assign out_valid = (r_count != '0);
    assign out_inst  = out_valid ? r_mem[r_rd_ptr] : c_nop;
    assign count     = r_count;
    assign err       = r_err;

    // Rejected commands still complete the handshake; they just never reach the FIFO.
    assign w_accept = cmd_valid && cmd_ready;
    assign w_push   = w_accept && w_legal && w_imm_ok && !flush;
    assign w_pop    = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_inst;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_accept && !(w_legal && w_imm_ok);
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
